// File: rtl/debouncer_pkg.sv
// Shared constants, width helpers and per-channel state for the debouncer bank.
package debouncer_pkg;

    localparam int DEF_CHANNELS     = 8;
    localparam int DEF_TICK_DIV     = 1;
    localparam int DEF_STABLE_TICKS = 255;

    // Widest stability counter the channel state can carry.
    localparam int CNT_MAX_W = 16;

    typedef struct packed {
        logic                 candidate;
        logic                 out;
        logic [CNT_MAX_W-1:0] count;
    } chan_state_t;

    function automatic int cnt_width(input int stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

    function automatic int div_width(input int tick_div);
        return (tick_div > 1) ? $clog2(tick_div) : 1;
    endfunction

endpackage

// File: rtl/debouncer_bank_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter and rise/fall strobes.
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    input  logic tick_i,
    output logic out_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_MAX_W-1:0] CNT_LAST = CNT_MAX_W'(STABLE_TICKS - 1);
    localparam chan_state_t RESET_STATE = '{candidate: RESET_VAL, out: RESET_VAL, count: '0};

    logic [1:0]  sync_q;
    logic        sync_s;
    chan_state_t state_q;
    chan_state_t state_d;
    logic        rise_q;
    logic        rise_d;
    logic        fall_q;
    logic        fall_d;

    // Two-flop synchroniser for the raw asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], in_i};
        end
    end

    assign sync_s = sync_q[1];

    // Candidate tracking, saturating stability count and output update.
    always_comb begin
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_s != state_q.candidate) begin
            state_d.candidate = sync_s;
            state_d.count     = '0;
        end else if (tick_i) begin
            if (state_q.count < CNT_LAST) begin
                state_d.count = state_q.count + CNT_MAX_W'(1);
            end else if (state_q.candidate != state_q.out) begin
                state_d.out = state_q.candidate;
                rise_d      = state_q.candidate;
                fall_d      = ~state_q.candidate;
            end else begin
                state_d.count = state_q.count;
            end
        end else begin
            state_d.count = state_q.count;
        end
    end

    // Channel state and strobe registers; strobes land with the out change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out_o  = state_q.out;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/debouncer_bank.sv
// Multi-channel debouncer bank with a shared tick prescaler.
// Optional sticky event flags and irq are built when DEBOUNCER_IRQ_EN is defined.
module debouncer_bank
    import debouncer_pkg::*;
#(
    parameter int   CHANNELS     = DEF_CHANNELS,
    parameter int   TICK_DIV     = DEF_TICK_DIV,
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in_i,
    output logic [CHANNELS-1:0] out_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o
`ifdef DEBOUNCER_IRQ_EN
    ,
    input  logic [CHANNELS-1:0] irq_clr_i,
    output logic [CHANNELS-1:0] events_o,
    output logic                irq_o
`endif
);

    localparam int            DW         = div_width(TICK_DIV);
    localparam logic [DW-1:0] PRESC_LAST = DW'(TICK_DIV - 1);

    if (CHANNELS < 1 || TICK_DIV < 1 || STABLE_TICKS < 1 ||
        cnt_width(STABLE_TICKS) > CNT_MAX_W) begin : g_param_check
        $error("debouncer_bank: CHANNELS, TICK_DIV and STABLE_TICKS must be >= 1 and fit the counter");
    end

    logic [DW-1:0] presc_q;
    logic [DW-1:0] presc_d;
    logic          tick_s;

    // Shared prescaler; with TICK_DIV=1 it sits at zero and ticks every cycle.
    always_comb begin
        tick_s = (presc_q == PRESC_LAST);
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + DW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS),
            .RESET_VAL   (RESET_VAL)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .in_i  (in_i[i]),
            .tick_i(tick_s),
            .out_o (out_o[i]),
            .rise_o(rise_o[i]),
            .fall_o(fall_o[i])
        );
    end

`ifdef DEBOUNCER_IRQ_EN
    logic [CHANNELS-1:0] events_q;
    logic [CHANNELS-1:0] events_d;

    // Sticky flags: a strobe in the same cycle as a clear keeps the flag set.
    always_comb begin
        events_d = (events_q & ~irq_clr_i) | rise_o | fall_o;
    end

    // Event flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            events_q <= '0;
        end else begin
            events_q <= events_d;
        end
    end

    assign events_o = events_q;
    assign irq_o    = |events_q;
`endif

endmodule

// File: tb/tb_debouncer_bank.sv
// Self-checking bench: two debouncer_bank configurations against a tick-counting reference model.
module tb_debouncer_bank;

    localparam int NI = 2;
    localparam int NC = 4;
    localparam int DIV  [NI] = '{1, 5};
    localparam int STAB [NI] = '{4, 3};
    localparam logic RV [NI] = '{1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NC-1:0] din;
    logic [NC-1:0] clr;
    logic [NC-1:0] out_a, rise_a, fall_a;
    logic [NC-1:0] out_b, rise_b, fall_b;
`ifdef DEBOUNCER_IRQ_EN
    logic [NC-1:0] ev_a, ev_b;
    logic          irq_a, irq_b;
`endif

    debouncer_bank #(.CHANNELS(NC), .TICK_DIV(1), .STABLE_TICKS(4), .RESET_VAL(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_i(din), .out_o(out_a), .rise_o(rise_a), .fall_o(fall_a)
`ifdef DEBOUNCER_IRQ_EN
        , .irq_clr_i(clr), .events_o(ev_a), .irq_o(irq_a)
`endif
    );

    debouncer_bank #(.CHANNELS(NC), .TICK_DIV(5), .STABLE_TICKS(3), .RESET_VAL(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_i(din), .out_o(out_b), .rise_o(rise_b), .fall_o(fall_b)
`ifdef DEBOUNCER_IRQ_EN
        , .irq_clr_i(clr), .events_o(ev_b), .irq_o(irq_b)
`endif
    );

    // Reference model: input delay line, candidate level, and ticks elapsed since it was adopted.
    logic [NC-1:0] m_s1 [NI];
    logic [NC-1:0] m_s2 [NI];
    logic [NC-1:0] m_cand [NI];
    logic [NC-1:0] m_out [NI];
    logic [NC-1:0] m_rise [NI];
    logic [NC-1:0] m_fall [NI];
    logic [NC-1:0] m_ev [NI];
    int            m_kt [NI][NC];
    int            m_n [NI];

    int n_tests;
    int n_fail;

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_s1[i]   = {NC{RV[i]}};
            m_s2[i]   = {NC{RV[i]}};
            m_cand[i] = {NC{RV[i]}};
            m_out[i]  = {NC{RV[i]}};
            m_rise[i] = '0;
            m_fall[i] = '0;
            m_ev[i]   = '0;
            m_n[i]    = 0;
            for (int c = 0; c < NC; c++) m_kt[i][c] = 0;
        end
    endtask

    task automatic model_edge();
        bit tick;
        for (int i = 0; i < NI; i++) begin
            tick = ((m_n[i] % DIV[i]) == DIV[i] - 1);
            m_n[i]++;
            m_ev[i] = (m_ev[i] & ~clr) | m_rise[i] | m_fall[i];
            m_rise[i] = '0;
            m_fall[i] = '0;
            for (int c = 0; c < NC; c++) begin
                if (m_s2[i][c] != m_cand[i][c]) begin
                    m_cand[i][c] = m_s2[i][c];
                    m_kt[i][c]   = 0;
                end else if (tick) begin
                    m_kt[i][c]++;
                    if (m_kt[i][c] >= STAB[i] && m_cand[i][c] != m_out[i][c]) begin
                        m_out[i][c]  = m_cand[i][c];
                        m_rise[i][c] = m_cand[i][c];
                        m_fall[i][c] = ~m_cand[i][c];
                    end
                end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = din;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out_a", 32'(out_a), 32'(m_out[0]));
        chk("rise_a", 32'(rise_a), 32'(m_rise[0]));
        chk("fall_a", 32'(fall_a), 32'(m_fall[0]));
        chk("out_b", 32'(out_b), 32'(m_out[1]));
        chk("rise_b", 32'(rise_b), 32'(m_rise[1]));
        chk("fall_b", 32'(fall_b), 32'(m_fall[1]));
`ifdef DEBOUNCER_IRQ_EN
        chk("events_a", 32'(ev_a), 32'(m_ev[0]));
        chk("events_b", 32'(ev_b), 32'(m_ev[1]));
        chk("irq_a", 32'(irq_a), 32'(|m_ev[0]));
        chk("irq_b", 32'(irq_b), 32'(|m_ev[1]));
`endif
    endtask

    task automatic step(input logic [NC-1:0] d);
        din = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int lat_a, lat_b, lat_bm, nstrobe;
        logic [NC-1:0] d;
        logic [NC-1:0] first_rise_a, first_rise_b;
        n_tests = 0;
        n_fail  = 0;
        din = '0;
        clr = '0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("reset_out_a", 32'(out_a), 32'hF);
        repeat (3) begin @(posedge clk); #1; check_all(); end
        rst = 1'b0;

        repeat (12) step(4'b0000);
        chk("settled_out_a", 32'(out_a), 32'h0);

        // Clean step on channel 0.
        lat_a = 0; lat_b = 0; lat_bm = 0; nstrobe = 0;
        for (int k = 1; k <= 25; k++) begin
            step(4'b0001);
            if (rise_a[0]) begin
                nstrobe++;
                if (lat_a == 0) lat_a = k;
            end
            if (rise_b[0] && lat_b == 0) lat_b = k;
            if (m_rise[1][0] && lat_bm == 0) lat_bm = k;
        end
        chk("step_lat_a", 32'(lat_a), 32'd7);
        chk("step_pulses_a", 32'(nstrobe), 32'd1);
        chk("step_lat_b", 32'(lat_b), 32'(lat_bm));

        // Bounce on channel 1: period-3 toggling never survives the window.
        nstrobe = 0;
        for (int seg = 0; seg < 10; seg++) begin
            d = 4'b0001;
            d[1] = (seg % 2 == 0);
            repeat (3) begin
                step(d);
                nstrobe += int'(rise_a[1]) + int'(fall_a[1]) + int'(rise_b[1]) + int'(fall_b[1]);
            end
        end
        chk("bounce_strobes", 32'(nstrobe), 32'd0);
        chk("bounce_out_a1", 32'(out_a[1]), 32'd0);
        lat_a = 0;
        for (int k = 1; k <= 12; k++) begin
            step(4'b0011);
            if (rise_a[1] && lat_a == 0) lat_a = k;
        end
        chk("bounce_hold_lat_a", 32'(lat_a), 32'd7);

        // Nine-cycle pulse on the prescaled instance is rejected.
        repeat (25) step(4'b0001);
        nstrobe = 0;
        repeat (9) step(4'b0011);
        repeat (25) begin
            step(4'b0001);
            nstrobe += int'(rise_b[1]);
        end
        chk("pulse9_rejected_b", 32'(nstrobe), 32'd0);

        // Simultaneous steps on channels 0 and 2.
        repeat (25) step(4'b0000);
        first_rise_a = '0; first_rise_b = '0; lat_a = 0;
        for (int k = 1; k <= 25; k++) begin
            step(4'b0101);
            if (rise_a != '0 && first_rise_a == '0) begin
                first_rise_a = rise_a;
                lat_a = k;
            end
            if (rise_b != '0 && first_rise_b == '0) first_rise_b = rise_b;
        end
        chk("parallel_rise_a", 32'(first_rise_a), 32'h5);
        chk("parallel_lat_a", 32'(lat_a), 32'd7);
        chk("parallel_rise_b", 32'(first_rise_b), 32'h5);
        chk("parallel_out_a", 32'(out_a), 32'h5);

`ifdef DEBOUNCER_IRQ_EN
        clr = 4'hF;
        step(4'b0101);
        clr = 4'h0;
        for (int k = 0; k < 12 && !m_fall[0][2]; k++) step(4'b0001);
        step(4'b0001);
        chk("irq_fall_event", 32'(ev_a[2]), 32'd1);
        chk("irq_fall_irq", 32'(irq_a), 32'd1);
        for (int k = 0; k < 12 && !m_rise[0][2]; k++) step(4'b0101);
        clr = 4'b0100;
        step(4'b0101);
        chk("irq_set_wins", 32'(ev_a[2]), 32'd1);
        clr = 4'hF;
        step(4'b0101);
        clr = 4'h0;
        chk("irq_lone_clear_ev", 32'(ev_a[2]), 32'd0);
        chk("irq_lone_clear_irq", 32'(irq_a), 32'd0);
`endif

        // Randomised traffic with an asynchronous reset in the middle.
        d = din;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 7) == 0) d[c] = ~d[c];
            end
`ifdef DEBOUNCER_IRQ_EN
            clr = 4'($urandom_range(0, 15)) & {4{($urandom_range(0, 3) == 0)}};
`endif
            step(d);
            if (k == 200) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_all();
                repeat (2) begin @(posedge clk); #1; check_all(); end
                rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
